// File: rtl/wb_sram16_ctrl_if.sv
// Wishbone classic single-cycle slave bus for the 16-bit SRAM controller.
//   adr     word address (AW bits), master -> slave
//   dat_wr  write data, master -> slave
//   dat_rd  read data, slave -> master
//   sel     byte enables, [0] low byte, [1] high byte
//   we      1 = write
//   stb     strobe
//   cyc     cycle
//   ack     single-cycle acknowledge, slave -> master
interface wb_sram16_ctrl_if #(
    parameter int AW = 18
);
    logic [AW-1:0] adr;
    logic [15:0]   dat_wr;
    logic [15:0]   dat_rd;
    logic [1:0]    sel;
    logic          we;
    logic          stb;
    logic          cyc;
    logic          ack;

    modport master (
        output adr, dat_wr, sel, we, stb, cyc,
        input  dat_rd, ack
    );

    modport slave (
        input  adr, dat_wr, sel, we, stb, cyc,
        output dat_rd, ack
    );
endinterface

// File: rtl/wb_sram16_ctrl.sv
// Wishbone slave driving an asynchronous 256K x 16 byte-lane SRAM.
// Each bus cycle becomes one timed SRAM access; strobe widths are counted
// in clock cycles via parameters. Every pin and the data-bus drive enable
// comes straight from a flop.
//   wb_clk_i, wb_rst_i  clock, async active-high reset
//   wb                  Wishbone slave port (wb_sram16_ctrl_if.slave)
//   sram_addr_          SRAM word address
//   sram_data_          SRAM bidirectional data
//   sram_ce_n/oe_n/we_n chip/output/write enables, active-low
//   sram_lb_n/ub_n      byte-lane enables, active-low
module wb_sram16_ctrl #(
    parameter int AW       = 18,
    parameter int RD_CYC   = 2,
    parameter int WR_SETUP = 1,
    parameter int WR_PULSE = 2,
    parameter int WR_HOLD  = 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    wb_sram16_ctrl_if.slave wb,
    output logic [AW-1:0] sram_addr_,
    inout  wire  [15:0]   sram_data_,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_lb_n,
    output logic          sram_ub_n
);
    // A zero count would make a state vanish; clamp to one cycle.
    localparam int RD_N = (RD_CYC   < 1) ? 1 : RD_CYC;
    localparam int SU_N = (WR_SETUP < 1) ? 1 : WR_SETUP;
    localparam int PW_N = (WR_PULSE < 1) ? 1 : WR_PULSE;
    localparam int HD_N = (WR_HOLD  < 1) ? 1 : WR_HOLD;
    localparam logic [3:0] RD_LD = 4'(RD_N - 1);
    localparam logic [3:0] SU_LD = 4'(SU_N - 1);
    localparam logic [3:0] PW_LD = 4'(PW_N - 1);
    localparam logic [3:0] HD_LD = 4'(HD_N - 1);

    typedef enum logic [2:0] {IDLE, RD, WR_SU, WR_PW, WR_HD, ACK} state_t;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [15:0]   dat;
        logic [1:0]    sel;
    } req_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    req_t        req_q, req_nx;
    logic [15:0] rdat_q, rdat_nx;
    logic        ce_q, oe_q, we_q, lb_q, ub_q, ack_q, den_q;
    logic        ce_nx, oe_nx, we_nx, lb_nx, ub_nx, ack_nx, den_nx;
    logic        pulse_n;

    // With no byte enabled the write pulse is suppressed but still timed.
    assign pulse_n = ~(|req_q.sel);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            req_q  <= '0;
            rdat_q <= '0;
            ce_q   <= 1'b1;
            oe_q   <= 1'b1;
            we_q   <= 1'b1;
            lb_q   <= 1'b1;
            ub_q   <= 1'b1;
            ack_q  <= 1'b0;
            den_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            req_q  <= req_nx;
            rdat_q <= rdat_nx;
            ce_q   <= ce_nx;
            oe_q   <= oe_nx;
            we_q   <= we_nx;
            lb_q   <= lb_nx;
            ub_q   <= ub_nx;
            ack_q  <= ack_nx;
            den_q  <= den_nx;
        end
    end

    // Computes the pin values for the *next* cycle, so pins are pure flops.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        req_nx   = req_q;
        rdat_nx  = rdat_q;
        ce_nx    = 1'b1;
        oe_nx    = 1'b1;
        we_nx    = 1'b1;
        lb_nx    = 1'b1;
        ub_nx    = 1'b1;
        ack_nx   = 1'b0;
        den_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (wb.stb && wb.cyc) begin
                    req_nx = '{adr: wb.adr, dat: wb.dat_wr, sel: wb.sel};
                    ce_nx  = 1'b0;
                    if (wb.we) begin
                        state_nx = WR_SU;
                        cnt_nx   = SU_LD;
                        lb_nx    = ~wb.sel[0];
                        ub_nx    = ~wb.sel[1];
                        den_nx   = 1'b1;
                    end else begin
                        state_nx = RD;
                        cnt_nx   = RD_LD;
                        oe_nx    = 1'b0;
                        lb_nx    = 1'b0;
                        ub_nx    = 1'b0;
                    end
                end
            end
            RD: begin
                if (cnt == 4'd0) begin
                    rdat_nx  = sram_data_;
                    state_nx = ACK;
                    ack_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                    ce_nx  = 1'b0;
                    oe_nx  = 1'b0;
                    lb_nx  = 1'b0;
                    ub_nx  = 1'b0;
                end
            end
            WR_SU, WR_PW, WR_HD: begin
                ce_nx  = 1'b0;
                lb_nx  = ~req_q.sel[0];
                ub_nx  = ~req_q.sel[1];
                den_nx = 1'b1;
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                    if (state == WR_PW) we_nx = pulse_n;
                end else if (state == WR_SU) begin
                    state_nx = WR_PW;
                    cnt_nx   = PW_LD;
                    we_nx    = pulse_n;
                end else if (state == WR_PW) begin
                    state_nx = WR_HD;
                    cnt_nx   = HD_LD;
                end else begin
                    state_nx = ACK;
                    ack_nx   = 1'b1;
                    ce_nx    = 1'b1;
                    lb_nx    = 1'b1;
                    ub_nx    = 1'b1;
                    den_nx   = 1'b0;
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign sram_addr_ = req_q.adr;
    assign sram_data_ = den_q ? req_q.dat : 16'hzzzz;
    assign sram_ce_n  = ce_q;
    assign sram_oe_n  = oe_q;
    assign sram_we_n  = we_q;
    assign sram_lb_n  = lb_q;
    assign sram_ub_n  = ub_q;
    assign wb.ack     = ack_q;
    assign wb.dat_rd  = rdat_q;
endmodule

// File: tb/tb_wb_sram16_ctrl.sv
// Directed bench: dut1 uses default timing, dut2 uses RD_CYC=3, WR_PULSE=4.
// Both see the same Wishbone stimulus; each has its own behavioural SRAM.
module tb_wb_sram16_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [17:0] t_adr = '0;
    logic [15:0] t_dat = '0;
    logic [1:0]  t_sel = '0;
    logic        t_we  = 1'b0;
    logic        t_stb = 1'b0;

    wb_sram16_ctrl_if #(.AW(18)) wb1 ();
    wb_sram16_ctrl_if #(.AW(18)) wb2 ();
    assign wb1.adr = t_adr;  assign wb2.adr = t_adr;
    assign wb1.dat_wr = t_dat; assign wb2.dat_wr = t_dat;
    assign wb1.sel = t_sel;  assign wb2.sel = t_sel;
    assign wb1.we = t_we;    assign wb2.we = t_we;
    assign wb1.stb = t_stb;  assign wb2.stb = t_stb;
    assign wb1.cyc = t_stb;  assign wb2.cyc = t_stb;

    logic [17:0] a1, a2;
    wire  [15:0] d1, d2;
    logic ce1, oe1, we1, lb1, ub1, ce2, oe2, we2, lb2, ub2;

    wb_sram16_ctrl dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(wb1.slave),
        .sram_addr_(a1), .sram_data_(d1), .sram_ce_n(ce1), .sram_oe_n(oe1),
        .sram_we_n(we1), .sram_lb_n(lb1), .sram_ub_n(ub1));

    wb_sram16_ctrl #(.RD_CYC(3), .WR_PULSE(4)) dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(wb2.slave),
        .sram_addr_(a2), .sram_data_(d2), .sram_ce_n(ce2), .sram_oe_n(oe2),
        .sram_we_n(we2), .sram_lb_n(lb2), .sram_ub_n(ub2));

    // Behavioural SRAMs: drive on read, write bytes on each clock we_n is low.
    logic [15:0] mem1 [0:262143];
    logic [15:0] mem2 [0:262143];
    assign d1 = (!ce1 && !oe1 && we1) ? mem1[a1] : 16'hzzzz;
    assign d2 = (!ce2 && !oe2 && we2) ? mem2[a2] : 16'hzzzz;

    always @(posedge clk) begin
        if (rst) begin
            mem1[18'h00005] <= 16'hBEEF;
            mem1[18'h3FFFF] <= 16'h5566;
            mem1[18'h00020] <= 16'h7777;
            mem1[18'h00010] <= 16'hA1A1;
            mem1[18'h00011] <= 16'hB2B2;
            mem2[18'h00005] <= 16'hBEEF;
            mem2[18'h3FFFF] <= 16'h5566;
        end else begin
            if (!ce1 && !we1) begin
                if (!lb1) mem1[a1][7:0]  <= d1[7:0];
                if (!ub1) mem1[a1][15:8] <= d1[15:8];
            end
            if (!ce2 && !we2) begin
                if (!lb2) mem2[a2][7:0]  <= d2[7:0];
                if (!ub2) mem2[a2][15:8] <= d2[15:8];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Per-cycle masks, bit c = cycle c after the request-sampling edge.
    // Active-low strobes set the bit when low; ack sets it when high.
    logic [31:0] m1_ce, m1_oe, m1_we, m1_lb, m1_ub, m1_ack;
    logic [31:0] m2_ce, m2_oe, m2_we, m2_ack;
    logic [15:0] bus1 [0:15];

    task automatic access(input logic we, input logic [17:0] adr,
                          input logic [15:0] dat, input logic [1:0] sel);
        m1_ce = '0; m1_oe = '0; m1_we = '0; m1_lb = '0; m1_ub = '0; m1_ack = '0;
        m2_ce = '0; m2_oe = '0; m2_we = '0; m2_ack = '0;
        @(negedge clk);
        t_we = we; t_adr = adr; t_dat = dat; t_sel = sel; t_stb = 1'b1;
        @(posedge clk);
        for (int c = 1; c < 16; c++) begin
            @(negedge clk);
            m1_ce[c] = ~ce1; m1_oe[c] = ~oe1; m1_we[c] = ~we1;
            m1_lb[c] = ~lb1; m1_ub[c] = ~ub1; m1_ack[c] = wb1.ack;
            m2_ce[c] = ~ce2; m2_oe[c] = ~oe2; m2_we[c] = ~we2; m2_ack[c] = wb2.ack;
            bus1[c] = d1;
            // Dropping stb mid-access must not abort the sequence.
            if (c == 1) t_stb = 1'b0;
        end
    endtask

    logic [31:0] bb_ce, bb_ack;
    logic [15:0] bb_rd;
    int phase;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pins1", 32'({ce1, oe1, we1, lb1, ub1, wb1.ack}), 32'h3E);
        chk("rst_pins2", 32'({ce2, oe2, we2, lb2, ub2, wb2.ack}), 32'h3E);
        chk("rst_addr1", 32'(a1), 32'h0);
        chk("rst_dat1", 32'(wb1.dat_rd), 32'h0);
        rst = 1'b0;

        // Read 0x00005 holding 0xBEEF.
        access(1'b0, 18'h00005, 16'h0, 2'b00);
        chk("rd_ce1", m1_ce, 32'h6);
        chk("rd_oe1", m1_oe, 32'h6);
        chk("rd_lbub1", m1_lb & m1_ub, 32'h6);
        chk("rd_we1", m1_we, 32'h0);
        chk("rd_ack1", m1_ack, 32'h8);
        chk("rd_dat1", 32'(wb1.dat_rd), 32'hBEEF);
        chk("rd_bus1", 32'({bus1[1], bus1[2]}), 32'hBEEFBEEF);
        chk("rd_oe2", m2_oe, 32'hE);
        chk("rd_ack2", m2_ack, 32'h10);
        chk("rd_dat2", 32'(wb2.dat_rd), 32'hBEEF);

        // Low-byte write of 0x12AB to 0x3FFFF (held 0x5566).
        access(1'b1, 18'h3FFFF, 16'h12AB, 2'b01);
        chk("wr_ce1", m1_ce, 32'h1E);
        chk("wr_lb1", m1_lb, 32'h1E);
        chk("wr_ub1", m1_ub, 32'h0);
        chk("wr_we1", m1_we, 32'hC);
        chk("wr_oe1", m1_oe, 32'h0);
        chk("wr_ack1", m1_ack, 32'h20);
        chk("wr_bus1", 32'({bus1[1], bus1[4]}), 32'h12AB12AB);
        chk("wr_keep_dat1", 32'(wb1.dat_rd), 32'hBEEF);
        chk("wr_ce2", m2_ce, 32'h7E);
        chk("wr_we2", m2_we, 32'h3C);
        chk("wr_ack2", m2_ack, 32'h80);
        access(1'b0, 18'h3FFFF, 16'h0, 2'b00);
        chk("rb_dat1", 32'(wb1.dat_rd), 32'h55AB);
        chk("rb_dat2", 32'(wb2.dat_rd), 32'h55AB);

        // Write with no byte lanes enabled.
        access(1'b1, 18'h00020, 16'h1111, 2'b00);
        chk("wr0_we1", m1_we, 32'h0);
        chk("wr0_lbub1", m1_lb | m1_ub, 32'h0);
        chk("wr0_ack1", m1_ack, 32'h20);
        access(1'b0, 18'h00020, 16'h0, 2'b00);
        chk("wr0_rb1", 32'(wb1.dat_rd), 32'h7777);

        // Back-to-back read 0x10 then write 0x11 with stb held throughout.
        bb_ce = '0; bb_ack = '0; bb_rd = '0; phase = 0;
        @(negedge clk);
        t_we = 1'b0; t_adr = 18'h00010; t_sel = 2'b00; t_stb = 1'b1;
        @(posedge clk);
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            bb_ce[c] = ~ce1; bb_ack[c] = wb1.ack;
            if (wb1.ack && phase == 0) begin
                bb_rd = wb1.dat_rd;
                t_we = 1'b1; t_adr = 18'h00011; t_dat = 16'hC3C3; t_sel = 2'b11;
                phase = 1;
            end else if (wb1.ack && phase == 1) begin
                t_stb = 1'b0;
                phase = 2;
            end
        end
        chk("bb_ce1", bb_ce, 32'h1E6);
        chk("bb_ack1", bb_ack, 32'h208);
        chk("bb_rd1", 32'(bb_rd), 32'hA1A1);
        repeat (15) @(posedge clk);
        access(1'b0, 18'h00011, 16'h0, 2'b00);
        chk("bb_rb1", 32'(wb1.dat_rd), 32'hC3C3);

        // Reset in the middle of the write pulse.
        @(negedge clk);
        t_we = 1'b1; t_adr = 18'h00030; t_dat = 16'hDDDD; t_sel = 2'b11; t_stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_stb = 1'b0;
        @(posedge clk);
        #2;
        chk("rstpw_pre_we1", 32'(we1), 32'h0);
        rst = 1'b1;
        #1;
        chk("rstpw_pins1", 32'({ce1, we1, lb1, ub1, wb1.ack}), 32'h1E);
        chk("rstpw_pins2", 32'({ce2, we2, lb2, ub2, wb2.ack}), 32'h1E);
        @(negedge clk);
        rst = 1'b0;
        m1_ack = '0;
        for (int c = 1; c < 12; c++) begin
            @(negedge clk);
            m1_ack[c] = wb1.ack | wb2.ack;
        end
        chk("rstpw_noack", m1_ack, 32'h0);
        chk("rstpw_dat1", 32'(wb1.dat_rd), 32'h0);
        access(1'b0, 18'h00005, 16'h0, 2'b00);
        chk("rstpw_rd_ack1", m1_ack, 32'h8);
        chk("rstpw_rd_dat1", 32'(wb1.dat_rd), 32'hBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
